// File: rtl/forth_pkg.sv
// Shared types and constants for the forth core and its boot/debug controller.
package forth_pkg;

    localparam int IADDR_W_DEF = 10;
    localparam int IDATA_W_DEF = 16;
    localparam int CYC_W_DEF   = 32;

    localparam logic [15:0] OP_NOP = 16'he040;
    localparam logic [15:0] OP_ADD = 16'he007;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_LOADED  = 3'd2,
        ST_RELEASE = 3'd3,
        ST_RUN     = 3'd4,
        ST_HALT    = 3'd5,
        ST_STEP    = 3'd6
    } ctrl_state_t;

    // The core is out of reset in every state from RELEASE onwards.
    function automatic logic core_released(input ctrl_state_t s);
        return (s == ST_RELEASE) || (s == ST_RUN) || (s == ST_HALT) || (s == ST_STEP);
    endfunction

endpackage

// File: rtl/forth_run_counter.sv
// Executed-cycle counter: synchronous clear, count enable, wraps modulo 2**W.
module forth_run_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!reset || clr_i) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/forth_boot_ctrl.sv
// Boot/debug controller for the forth core: program load, run/halt/step, breakpoint, cycle count.
//   state   | meaning
//   IDLE    | core in reset, waiting for first program word or go
//   LOAD    | streaming program words into instruction RAM
//   LOADED  | program complete, core still in reset
//   RELEASE | reset dropped, core fetching its first instruction
//   RUN     | core clocked unless breakpoint hits
//   HALT    | core frozen
//   STEP    | one core cycle, then back to HALT
module forth_boot_ctrl
    import forth_pkg::*;
#(
    parameter int IADDR_W = IADDR_W_DEF,
    parameter int IDATA_W = IDATA_W_DEF,
    parameter int CYC_W   = CYC_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               s_valid,
    input  logic [IDATA_W-1:0] s_data,
    input  logic               s_last,
    output logic               s_ready,
    input  logic               go,
    input  logic               halt,
    input  logic               step,
    input  logic               reload,
    input  logic               bp_en,
    input  logic [IADDR_W-1:0] bp_addr,
    input  logic [IADDR_W-1:0] iaddr,
    output logic               imem_we,
    output logic [IADDR_W-1:0] imem_waddr,
    output logic [IDATA_W-1:0] imem_wdata,
    output logic               cpu_reset,
    output logic               cpu_ce,
    output logic [2:0]         state_o,
    output logic [IADDR_W:0]   load_count,
    output logic               err_overflow,
    output logic [CYC_W-1:0]   cycles
);

    localparam logic [IADDR_W:0] LC_ONE = 1;

    ctrl_state_t state_q, state_d;

    logic               hs, in_idle, at_max, wr_ok, bp_hit, run_start;
    logic [IADDR_W-1:0] ptr_q, wptr;
    logic [IADDR_W-1:0] waddr_q;
    logic [IDATA_W-1:0] wdata_q;
    logic [IADDR_W:0]   load_count_q;
    logic               we_q, err_q, cpu_reset_q, bp_skip_q;

    assign in_idle = (state_q == ST_IDLE);
    assign hs      = s_valid && s_ready;
    assign wptr    = in_idle ? '0 : ptr_q;
    assign at_max  = &wptr;
    // Once overflowed, the rest of the stream is drained without writes.
    assign wr_ok   = in_idle || !err_q;
    assign bp_hit  = bp_en && (iaddr == bp_addr) && !bp_skip_q;
    assign run_start = ((state_q == ST_IDLE) || (state_q == ST_LOADED)) && (state_d == ST_RELEASE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (reload) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (hs)      state_d = s_last ? ST_LOADED : ST_LOAD;
                    else if (go) state_d = ST_RELEASE;
                end
                ST_LOAD:    if (hs && s_last) state_d = ST_LOADED;
                ST_LOADED:  if (go) state_d = ST_RELEASE;
                ST_RELEASE: state_d = ST_RUN;
                ST_RUN:     if (halt || bp_hit) state_d = ST_HALT;
                ST_HALT: begin
                    if (step)    state_d = ST_STEP;
                    else if (go) state_d = ST_RUN;
                end
                ST_STEP:    state_d = ST_HALT;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        s_ready = (state_q == ST_IDLE) || (state_q == ST_LOAD);
        cpu_ce  = ((state_q == ST_RUN) && !bp_hit) || (state_q == ST_STEP);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_q        <= '0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            load_count_q <= '0;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            cpu_reset_q  <= 1'b1;
            bp_skip_q    <= 1'b0;
        end else begin
            cpu_reset_q <= !core_released(state_d);
            bp_skip_q   <= (state_q == ST_HALT) && (state_d == ST_RUN);
            we_q        <= hs && wr_ok;
            if (hs) begin
                if (wr_ok) begin
                    waddr_q      <= wptr;
                    wdata_q      <= s_data;
                    load_count_q <= in_idle ? LC_ONE : load_count_q + LC_ONE;
                    ptr_q        <= at_max ? wptr : wptr + 1'b1;
                end
                err_q <= (in_idle ? 1'b0 : err_q) | (!s_last && at_max);
            end
        end
    end

    forth_run_counter #(.W(CYC_W)) u_cycles (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (run_start),
        .en_i    (cpu_ce),
        .count_o (cycles)
    );

    assign imem_we      = we_q;
    assign imem_waddr   = waddr_q;
    assign imem_wdata   = wdata_q;
    assign cpu_reset    = cpu_reset_q;
    assign state_o      = state_q;
    assign load_count   = load_count_q;
    assign err_overflow = err_q;

endmodule

// File: tb/tb_forth_boot_ctrl.sv
// Directed bench for forth_boot_ctrl with a tiny behavioural core (literal push / add) on the RAM.
module tb_forth_boot_ctrl;
    import forth_pkg::*;

    logic        clk = 1'b0;
    logic        reset, s_valid, s_last, go, halt, step, reload, bp_en;
    logic [15:0] s_data;
    logic [9:0]  bp_addr, iaddr;
    logic        s_ready, imem_we, cpu_reset, cpu_ce, err_overflow;
    logic [9:0]  imem_waddr;
    logic [15:0] imem_wdata;
    logic [2:0]  state_o;
    logic [10:0] load_count;
    logic [31:0] cycles;

    logic        s2_valid, s2_last;
    logic [15:0] s2_data;
    logic        s2_ready, imem2_we, cpu2_reset, cpu2_ce, err2;
    logic [1:0]  imem2_waddr;
    logic [15:0] imem2_wdata;
    logic [2:0]  state2;
    logic [2:0]  load_count2;
    logic [31:0] cycles2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    forth_boot_ctrl dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
        .s_ready(s_ready), .go(go), .halt(halt), .step(step), .reload(reload),
        .bp_en(bp_en), .bp_addr(bp_addr), .iaddr(iaddr), .imem_we(imem_we),
        .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .cpu_reset(cpu_reset),
        .cpu_ce(cpu_ce), .state_o(state_o), .load_count(load_count),
        .err_overflow(err_overflow), .cycles(cycles)
    );

    forth_boot_ctrl #(.IADDR_W(2)) dut2 (
        .clk(clk), .reset(reset), .s_valid(s2_valid), .s_data(s2_data), .s_last(s2_last),
        .s_ready(s2_ready), .go(1'b0), .halt(1'b0), .step(1'b0), .reload(1'b0),
        .bp_en(1'b0), .bp_addr(2'd0), .iaddr(2'd0), .imem_we(imem2_we),
        .imem_waddr(imem2_waddr), .imem_wdata(imem2_wdata), .cpu_reset(cpu2_reset),
        .cpu_ce(cpu2_ce), .state_o(state2), .load_count(load_count2),
        .err_overflow(err2), .cycles(cycles2)
    );

    // Behavioural core: bit15=0 pushes the literal, OP_ADD adds, anything else is a no-op.
    logic [15:0] imem [0:1023];
    logic [9:0]  pc;
    logic [15:0] tos, nos, instr;
    logic [3:0]  psp;

    assign iaddr = pc;
    assign instr = imem[pc];

    always @(posedge clk) begin
        if (imem_we) imem[imem_waddr] <= imem_wdata;
    end

    always @(posedge clk) begin
        if (cpu_reset) begin
            pc <= '0; tos <= '0; nos <= '0; psp <= '0;
        end else if (cpu_ce) begin
            pc <= pc + 10'd1;
            if (!instr[15]) begin
                nos <= tos; tos <= instr; psp <= psp + 4'd1;
            end else if (instr == OP_ADD) begin
                tos <= tos + nos; nos <= '0; psp <= psp - 4'd1;
            end else if (instr == OP_NOP) begin
                tos <= tos;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
        go = 1'b0; halt = 1'b0; step = 1'b0; reload = 1'b0; bp_en = 1'b0; bp_addr = '0;
        s2_valid = 1'b0; s2_last = 1'b0; s2_data = '0;
        tick(); tick();
        check("rst_state", state_o, ST_IDLE);
        check("rst_cpu_reset", cpu_reset, 1);
        check("rst_cpu_ce", cpu_ce, 0);
        check("rst_we", imem_we, 0);
        check("rst_load_count", load_count, 0);
        check("rst_err", err_overflow, 0);
        check("rst_cycles", cycles, 0);
        check("rst_s_ready", s_ready, 1);
        reset = 1'b1;

        // Load 0001, 0002, e007
        s_valid = 1'b1; s_data = 16'h0001; s_last = 1'b0;
        tick();
        check("ld0_we", imem_we, 1); check("ld0_addr", imem_waddr, 0); check("ld0_data", imem_wdata, 16'h0001);
        check("ld0_state", state_o, ST_LOAD); check("ld0_cnt", load_count, 1);
        s_data = 16'h0002;
        tick();
        check("ld1_we", imem_we, 1); check("ld1_addr", imem_waddr, 1); check("ld1_data", imem_wdata, 16'h0002);
        s_data = OP_ADD; s_last = 1'b1;
        tick();
        check("ld2_we", imem_we, 1); check("ld2_addr", imem_waddr, 2); check("ld2_data", imem_wdata, 16'he007);
        check("ld2_state", state_o, ST_LOADED); check("ld2_cnt", load_count, 3); check("ld2_ready", s_ready, 0);
        s_valid = 1'b0; s_last = 1'b0;
        tick();
        check("ld_we_off", imem_we, 0);

        // go -> RELEASE -> RUN, three executed cycles
        go = 1'b1;
        tick();
        check("rel_state", state_o, ST_RELEASE); check("rel_cpu_reset", cpu_reset, 0);
        check("rel_ce", cpu_ce, 0); check("rel_cycles", cycles, 0);
        go = 1'b0;
        tick();
        check("run_state", state_o, ST_RUN); check("run_ce", cpu_ce, 1); check("run_iaddr", iaddr, 0);
        tick(); tick(); tick();
        check("run3_tos", tos, 3); check("run3_psp", psp, 1); check("run3_cycles", cycles, 3);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        check("halt_state", state_o, ST_HALT); check("halt_ce", cpu_ce, 0); check("halt_cycles", cycles, 4);
        tick();
        check("halt_frozen", cycles, 4);
        reload = 1'b1;
        tick();
        reload = 1'b0;
        check("reload_state", state_o, ST_IDLE); check("reload_cpu_reset", cpu_reset, 1);
        check("reload_keep_cnt", load_count, 3);

        // Breakpoint at address 2
        bp_en = 1'b1; bp_addr = 10'd2; go = 1'b1;
        tick();
        go = 1'b0;
        tick(); tick(); tick();
        check("bp_iaddr", iaddr, 2); check("bp_ce", cpu_ce, 0); check("bp_cycles", cycles, 2);
        tick();
        check("bp_state", state_o, ST_HALT); check("bp_cycles_hold", cycles, 2); check("bp_tos", tos, 2);

        // Single step from the breakpoint
        step = 1'b1;
        tick();
        step = 1'b0;
        check("step_state", state_o, ST_STEP); check("step_ce", cpu_ce, 1);
        tick();
        check("step_back", state_o, ST_HALT); check("step_ce_off", cpu_ce, 0);
        check("step_tos", tos, 3); check("step_cycles", cycles, 3);

        // Back to the breakpoint and resume with go
        reload = 1'b1; tick(); reload = 1'b0;
        go = 1'b1; tick(); go = 1'b0;
        tick(); tick(); tick(); tick();
        check("bp2_state", state_o, ST_HALT); check("bp2_cycles", cycles, 2);
        go = 1'b1;
        tick();
        go = 1'b0;
        check("resume_state", state_o, ST_RUN); check("resume_iaddr", iaddr, 2); check("resume_ce", cpu_ce, 1);
        tick();
        check("resume_run", state_o, ST_RUN); check("resume_past", iaddr, 3);
        check("resume_tos", tos, 3); check("resume_cycles", cycles, 3);

        // halt and go together in RUN: halt wins
        halt = 1'b1; go = 1'b1;
        tick();
        halt = 1'b0; go = 1'b0;
        check("halt_go_state", state_o, ST_HALT);

        // Reset in the middle of a load
        reload = 1'b1; tick(); reload = 1'b0;
        s_valid = 1'b1; s_data = 16'h1234;
        tick();
        check("mid_load_state", state_o, ST_LOAD);
        reset = 1'b0;
        tick();
        check("mrst_state", state_o, ST_IDLE); check("mrst_cpu_reset", cpu_reset, 1);
        check("mrst_we", imem_we, 0); check("mrst_waddr", imem_waddr, 0); check("mrst_wdata", imem_wdata, 0);
        check("mrst_cnt", load_count, 0); check("mrst_err", err_overflow, 0); check("mrst_cycles", cycles, 0);
        reset = 1'b1; s_valid = 1'b0;
        tick();

        // Overflow on the IADDR_W=2 instance: 6 words, last on the sixth
        for (int k = 1; k <= 6; k++) begin
            s2_valid = 1'b1; s2_data = 16'(16'h0100 + k); s2_last = (k == 6);
            tick();
            if (k <= 4) begin
                check($sformatf("ovf_we%0d", k), imem2_we, 1);
                check($sformatf("ovf_addr%0d", k), imem2_waddr, k - 1);
                check($sformatf("ovf_data%0d", k), imem2_wdata, 16'h0100 + k);
            end else begin
                check($sformatf("ovf_drain%0d", k), imem2_we, 0);
            end
            check($sformatf("ovf_err%0d", k), err2, (k >= 4) ? 1 : 0);
        end
        s2_valid = 1'b0; s2_last = 1'b0;
        check("ovf_state", state2, ST_LOADED); check("ovf_cnt", load_count2, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
